// File: rtl/demux_1x16_collect.sv
// 1:16 serial-to-parallel collector: steers serial bits into a 16-bit word,
// with a one-word output buffer so the next word can assemble while it waits.
module demux_1x16_collect #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_bit,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  bit_cnt
);

    logic [15:0] asm_reg;
    logic [15:0] asm_next;
    logic [3:0]  wr_idx;
    logic        in_xfer;
    logic        out_xfer;
    logic        last_bit;
    logic        complete;

    // Write index is the write counter, mirrored when the first bit is the MSB.
    assign wr_idx = LSB_FIRST ? bit_cnt : (4'd15 - bit_cnt);

    // Last slot can only fill once the output buffer is empty; state-only path.
    assign in_ready = !(out_valid && (bit_cnt == 4'd15));

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign last_bit = (bit_cnt == 4'd15);
    assign complete = in_xfer && last_bit && !flush;

    // Demux: the addressed assembly position takes the incoming bit.
    always_comb begin
        asm_next = asm_reg;
        asm_next[wr_idx] = in_bit;
    end

    // Assembly register and bit counter; flush discards the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_reg <= '0;
            bit_cnt <= '0;
        end else if (flush) begin
            asm_reg <= '0;
            bit_cnt <= '0;
        end else if (in_xfer) begin
            if (last_bit) begin
                asm_reg <= '0;
                bit_cnt <= '0;
            end else begin
                asm_reg <= asm_next;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Output buffer: load on completion, drop valid once the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            out_data  <= asm_next;
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/demux_1x16_collect.md
DEMUX_1X16_COLLECT -- requirements
Module: demux_1x16_collect

Interface
REQ-001 Parameter LSB_FIRST, default 1; 1 = first accepted bit lands in out_data[0], 0 = first accepted bit lands in out_data[15].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_bit  input  1  serial data bit.
REQ-005 in_valid  input  1  in_bit is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_bit this cycle; transfer = in_valid && in_ready at rising edge.
REQ-007 flush  input  1  synchronous discard of the partially assembled word.
REQ-008 out_data  output  16  completed 16-bit word.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer takes out_data; transfer = out_valid && out_ready at rising edge.
REQ-011 bit_cnt  output  4  number of bits accepted into the current partial word (0..15).

Function
REQ-012 Block SHALL be the inverse of the 16:1 select mux: a 4-bit write index steers each serial bit into one of 16 assembly-register positions.
REQ-013 Write index SHALL be bit_cnt when LSB_FIRST=1 and 15-bit_cnt when LSB_FIRST=0.
REQ-014 On each input transfer the assembly bit at the write index SHALL take in_bit, and bit_cnt SHALL increment by 1, wrapping 15 -> 0.
REQ-015 Assembly-register bits not yet written in the current word SHALL be 0; the assembly register SHALL clear when a word completes.
REQ-016 When the transfer with bit_cnt=15 occurs, out_data SHALL load the full 16-bit word, including that final bit, and out_valid SHALL be 1 from the following cycle (latency 1 clock after the 16th bit).
REQ-017 out_data SHALL remain stable while out_valid=1 and no output transfer occurs.
REQ-018 An output transfer without a simultaneous word completion SHALL clear out_valid on the next cycle; out_data SHALL retain its last value.
REQ-019 Double buffering: input transfers for bit_cnt 0..14 SHALL proceed while out_valid=1.
REQ-020 in_ready SHALL equal NOT (out_valid AND bit_cnt==15), combinational from registered state only, with no path from out_ready.
REQ-021 Consequence of REQ-020: the 16th bit of the next word SHALL stall until out_valid has cleared; this holds even in a cycle where out_ready=1.
REQ-022 flush=1 SHALL set bit_cnt to 0 and clear the assembly register on the next edge, and SHALL NOT affect out_data or out_valid.
REQ-023 If flush and an input transfer coincide, flush SHALL win and the bit SHALL be discarded.
REQ-024 in_bit SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-025 While rst=1, independent of clk: bit_cnt=0, assembly register=0, out_data=16'h0000, out_valid=0, in_ready=1.
REQ-026 A word partially assembled when rst asserts SHALL be lost; the first transfer after rst deasserts SHALL be bit index 0 of a new word.

Verification
REQ-027 LSB_FIRST=1, out_ready=1, 16 back-to-back bits of 16'hA5C3 sent LSB first -> out_valid=1 one cycle after the 16th bit, out_data=16'hA5C3, out_valid=0 the cycle after.
REQ-028 LSB_FIRST=0, bits of 16'h8001 sent MSB first -> out_data=16'h8001.
REQ-029 out_ready=0, 16'h1234 then 15 bits of 16'hFFFF -> bit_cnt=15, in_ready=0, out_data stays 16'h1234; raise out_ready -> out_valid drops, in_ready=1, 16th bit accepted, out_data=16'hFFFF one cycle later.
REQ-030 5 bits sent, then flush together with a valid bit -> bit_cnt=0, out_valid unchanged; next 16 bits of 16'h00FF -> out_data=16'h00FF.
REQ-031 rst asserted asynchronously mid-word with bit_cnt=9 and out_valid=1 -> all outputs at reset values immediately, without waiting for a clock edge; next 16 bits form a correct word.
REQ-032 in_valid toggled randomly with random out_ready -> every emitted word matches a scoreboard built from accepted bits only, with no loss or duplication.
